y86_instr_byte_decoder: RTL and testbench

Byte-serial Y86-64 instruction decoder for the SEQ front end. It accepts instruction bytes one per cycle from instruction memory over a valid/ready handshake and assembles variable-length instructions (1, 2, 9 or 10 bytes). It presents the decoded fields (icode, ifun, rA, rB, valC, length, PC, valP) over a second valid/ready handshake to the decode/execute stages. It is the consumer-side counterpart of the SEQ instruction encoder and feeds the ALU blocks.

---
 rtl/y86_pkg.sv | 31 +++
 rtl/y86_instr_byte_decoder_if.sv | 25 ++
 rtl/y86_icode_info.sv | 16 +
 rtl/y86_instr_byte_decoder.sv | 81 ++++++++
 tb/tb_y86_instr_byte_decoder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 opcode constants, decoder state type and field-presence helpers.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {S_OPC, S_REG, S_CONST, S_DONE} state_t;

  function automatic logic need_regids(input logic [3:0] icode);
    return icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic need_valc(input logic [3:0] icode);
    return icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
  endfunction

  function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
    return (icode == I_RRMOVQ || icode == I_JXX) ? ifun <= 4'd6 :
           (icode == I_OPQ) ? ifun <= 4'd3 : ifun == 4'd0;
  endfunction
endpackage

// File: rtl/y86_instr_byte_decoder_if.sv
// y86_instr_byte_decoder_if: byte-in handshake plus decoded-instruction handshake bundle.
interface y86_instr_byte_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [3:0]  ilen;
  logic [63:0] pc;
  logic [63:0] valP;
  logic        instr_err;
  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, icode, ifun, rA, rB, valC, ilen, pc, valP, instr_err
  );
  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, icode, ifun, rA, rB, valC, ilen, pc, valP, instr_err
  );
endinterface

// File: rtl/y86_icode_info.sv
// y86_icode_info: classifies an opcode byte into field presence, length and legality.
module y86_icode_info
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic [3:0] ilen,
  output logic       err
);
  assign need_regids_o = need_regids(icode);
  assign need_valc_o   = need_valc(icode);
  assign ilen = 4'd1 + (need_regids_o ? 4'd1 : 4'd0) + (need_valc_o ? 4'd8 : 4'd0);
  assign err  = icode > I_POPQ || !ifun_ok(icode, ifun);
endmodule

// File: rtl/y86_instr_byte_decoder.sv
// y86_instr_byte_decoder: assembles byte-serial Y86-64 instructions into decoded fields.
module y86_instr_byte_decoder
  import y86_pkg::*;
(
  input logic clk,
  input logic rst_n,
  y86_instr_byte_decoder_if.slave bus
);
  state_t      state, state_n;
  logic [63:0] pc_cnt;
  logic [2:0]  cnt;
  logic        acc, hs, nr, nv, ierr;
  logic [3:0]  il;

  y86_icode_info u_info (
    .icode(bus.in_byte[7:4]),
    .ifun(bus.in_byte[3:0]),
    .need_regids_o(nr),
    .need_valc_o(nv),
    .ilen(il),
    .err(ierr)
  );

  assign bus.in_ready  = state != S_DONE;
  assign bus.out_valid = state == S_DONE;
  assign acc = bus.in_valid && bus.in_ready;
  assign hs  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_OPC;
    else state <= state_n;

  always_comb begin
    state_n = state;
    if (acc)
      state_n = state == S_OPC ? (nr ? S_REG : nv ? S_CONST : S_DONE) :
                state == S_REG ? (need_valc(bus.icode) ? S_CONST : S_DONE) :
                (cnt == 3'd7 ? S_DONE : S_CONST);
    if (hs) state_n = S_OPC;
  end

  // byte 0 fixes length, pc and valP up front; later bytes only fill rA/rB/valC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_cnt        <= '0;
      cnt           <= '0;
      bus.icode     <= '0;
      bus.ifun      <= '0;
      bus.rA        <= REG_NONE;
      bus.rB        <= REG_NONE;
      bus.valC      <= '0;
      bus.ilen      <= '0;
      bus.pc        <= '0;
      bus.valP      <= '0;
      bus.instr_err <= 1'b0;
    end else begin
      if (acc) pc_cnt <= pc_cnt + 64'd1;
      if (acc && state == S_OPC) begin
        bus.icode     <= bus.in_byte[7:4];
        bus.ifun      <= bus.in_byte[3:0];
        bus.ilen      <= il;
        bus.instr_err <= ierr;
        bus.pc        <= pc_cnt;
        bus.valP      <= pc_cnt + 64'(il);
        cnt           <= '0;
      end
      if (acc && state == S_REG) begin
        bus.rA <= bus.in_byte[7:4];
        bus.rB <= bus.in_byte[3:0];
      end
      if (acc && state == S_CONST) begin
        bus.valC[{cnt, 3'b000} +: 8] <= bus.in_byte;
        cnt <= cnt + 3'd1;
      end
      if (hs) begin
        bus.rA   <= REG_NONE;
        bus.rB   <= REG_NONE;
        bus.valC <= '0;
      end
    end
endmodule

// File: tb/tb_y86_instr_byte_decoder.sv
// tb_y86_instr_byte_decoder: directed byte streams checked against literals and a byte-queue model.
module tb_y86_instr_byte_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  y86_instr_byte_decoder_if bus ();
  y86_instr_byte_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // instruction length and highest legal ifun, indexed by icode
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int maxf    [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

  logic [7:0]  q[$];
  logic [63:0] mcnt = '0;
  logic [63:0] mpc = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = '0;
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst icode", 64'(bus.icode), 64'd0);
      chk("rst ifun", 64'(bus.ifun), 64'd0);
      chk("rst rA", 64'(bus.rA), 64'hF);
      chk("rst rB", 64'(bus.rB), 64'hF);
      chk("rst valC", bus.valC, 64'd0);
      chk("rst ilen", 64'(bus.ilen), 64'd0);
      chk("rst pc", bus.pc, 64'd0);
      chk("rst valP", bus.valP, 64'd0);
      chk("rst err", 64'(bus.instr_err), 64'd0);
    end else begin
      automatic int len = q.size() != 0 ? len_tab[q[0][7:4]] : 0;
      automatic logic ev = q.size() != 0 && q.size() == len;
      chk("m out_valid", 64'(bus.out_valid), 64'(ev));
      chk("m in_ready", 64'(bus.in_ready), 64'(!ev));
      if (ev) begin
        automatic int ic = int'(q[0][7:4]);
        automatic int fn = int'(q[0][3:0]);
        automatic logic hasreg = len == 2 || len == 10;
        automatic logic [63:0] vc = '0;
        if (len >= 9) for (int k = 0; k < 8; k++) vc[8*k +: 8] = q[len - 8 + k];
        chk("m icode", 64'(bus.icode), 64'(ic));
        chk("m ifun", 64'(bus.ifun), 64'(fn));
        chk("m rA", 64'(bus.rA), hasreg ? 64'(q[1][7:4]) : 64'hF);
        chk("m rB", 64'(bus.rB), hasreg ? 64'(q[1][3:0]) : 64'hF);
        chk("m valC", bus.valC, vc);
        chk("m ilen", 64'(bus.ilen), 64'(len));
        chk("m pc", bus.pc, mpc);
        chk("m valP", bus.valP, mpc + 64'(len));
        chk("m err", 64'(bus.instr_err), 64'(ic >= 12 || fn > maxf[ic]));
        if (bus.out_ready) q.delete();
      end
      if (bus.in_valid && bus.in_ready) begin
        if (q.size() == 0) mpc = mcnt;
        q.push_back(bus.in_byte);
        mcnt++;
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    automatic bit ok = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) chk("send timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b[], input int gap);
    foreach (b[i]) send(b[i], gap ? (i % 3) + 1 : 0);
  endtask

  task automatic expect_out(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [63:0] vc, input logic [3:0] len,
                            input logic [63:0] p, input logic [63:0] vp, input logic e, input int hold);
    automatic bit ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.out_valid;
    end
    chk("out_valid seen", 64'(ok), 64'd1);
    chk("icode", 64'(bus.icode), 64'(ic));
    chk("ifun", 64'(bus.ifun), 64'(fn));
    chk("rA", 64'(bus.rA), 64'(ra));
    chk("rB", 64'(bus.rB), 64'(rb));
    chk("valC", bus.valC, vc);
    chk("ilen", 64'(bus.ilen), 64'(len));
    chk("pc", bus.pc, p);
    chk("valP", bus.valP, vp);
    chk("instr_err", 64'(bus.instr_err), 64'(e));
    @(posedge clk); #1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold out_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk("async out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] irmov [] = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] jne   [] = '{8'h74, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h00, 0);
    expect_out(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 4'd1, 64'd0, 64'd1, 1'b0, 0);
    send_seq(jne, 0);
    expect_out(4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 4'd9, 64'd1, 64'd10, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(irmov[i], 0);
    pulse_reset();
    send(8'h10, 0);
    expect_out(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 4'd1, 64'd0, 64'd1, 1'b0, 0);
    pulse_reset();
    send_seq(irmov, 0);
    expect_out(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 4'd10, 64'd0, 64'd10, 1'b0, 0);
    send_seq(irmov, 1);
    expect_out(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 4'd10, 64'd10, 64'd20, 1'b0, 0);
    send(8'h60, 0);
    send(8'h23, 0);
    expect_out(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 4'd2, 64'd20, 64'd22, 1'b0, 5);
    send(8'hC5, 0);
    expect_out(4'hC, 4'h5, 4'hF, 4'hF, 64'd0, 4'd1, 64'd22, 64'd23, 1'b1, 0);
    send(8'h15, 0);
    expect_out(4'h1, 4'h5, 4'hF, 4'hF, 64'd0, 4'd1, 64'd23, 64'd24, 1'b1, 0);
    send(8'h67, 0);
    send(8'h12, 0);
    expect_out(4'h6, 4'h7, 4'h1, 4'h2, 64'd0, 4'd2, 64'd24, 64'd26, 1'b1, 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
